fixed_gqa_weight_scheduler: RTL and testbench

FIXED_GQA_WEIGHT_SCHEDULER -- requirements
Module: fixed_gqa_weight_scheduler

---
 rtl/fixed_gqa_weight_scheduler.sv | 96 +++++++++
 tb/tb_fixed_gqa_weight_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_gqa_weight_scheduler.sv
// fixed_gqa_weight_scheduler: routes one shared weight stream to Q/K/V/O targets in fixed block order
module fixed_gqa_weight_scheduler #(
  parameter int WEIGHT_PRECISION_0 = 8,
  parameter int WEIGHT_PARALLELISM = 4,
  parameter int Q_BEATS            = 16,
  parameter int KV_BEATS           = 4,
  parameter int O_BEATS            = 16,
  parameter int NUM_PASSES         = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  output logic                                          busy,
  output logic                                          done,
  output logic [1:0]                                    sel,
  input  logic [WEIGHT_PRECISION_0*WEIGHT_PARALLELISM-1:0] weight_in,
  input  logic                                          weight_in_valid,
  output logic                                          weight_in_ready,
  output logic [WEIGHT_PRECISION_0*WEIGHT_PARALLELISM-1:0] q_projection_weight,
  output logic [WEIGHT_PRECISION_0*WEIGHT_PARALLELISM-1:0] k_projection_weight,
  output logic [WEIGHT_PRECISION_0*WEIGHT_PARALLELISM-1:0] v_projection_weight,
  output logic [WEIGHT_PRECISION_0*WEIGHT_PARALLELISM-1:0] o_projection_weight,
  output logic                                          q_projection_weight_valid,
  output logic                                          k_projection_weight_valid,
  output logic                                          v_projection_weight_valid,
  output logic                                          o_projection_weight_valid,
  input  logic                                          q_projection_weight_ready,
  input  logic                                          k_projection_weight_ready,
  input  logic                                          v_projection_weight_ready,
  input  logic                                          o_projection_weight_ready
);
  localparam int MAX_QKV = Q_BEATS > KV_BEATS ? Q_BEATS : KV_BEATS;
  localparam int MAX_B   = MAX_QKV > O_BEATS ? MAX_QKV : O_BEATS;
  localparam int BW      = MAX_B > 1 ? $clog2(MAX_B) : 1;
  localparam int PW      = NUM_PASSES > 1 ? $clog2(NUM_PASSES) : 1;
  typedef enum logic [2:0] {IDLE, LOAD_Q, LOAD_K, LOAD_V, LOAD_O} state_t;
  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_beat, w_beat_nxt, w_beat_lim;
  logic [PW-1:0] r_pass, w_pass_nxt;
  logic          r_done, w_done_nxt, w_hs, w_last_beat, w_last_pass;
  assign q_projection_weight = weight_in;
  assign k_projection_weight = weight_in;
  assign v_projection_weight = weight_in;
  assign o_projection_weight = weight_in;
  // pure combinational routing: the selected target sees the stream directly
  assign q_projection_weight_valid = (r_state == LOAD_Q) & weight_in_valid;
  assign k_projection_weight_valid = (r_state == LOAD_K) & weight_in_valid;
  assign v_projection_weight_valid = (r_state == LOAD_V) & weight_in_valid;
  assign o_projection_weight_valid = (r_state == LOAD_O) & weight_in_valid;
  assign weight_in_ready = r_state == LOAD_Q ? q_projection_weight_ready :
                           r_state == LOAD_K ? k_projection_weight_ready :
                           r_state == LOAD_V ? v_projection_weight_ready :
                           r_state == LOAD_O ? o_projection_weight_ready : 1'b0;
  assign sel = r_state == LOAD_K ? 2'd1 : r_state == LOAD_V ? 2'd2 : r_state == LOAD_O ? 2'd3 : 2'd0;
  assign busy = r_state != IDLE;
  assign done = r_done;
  assign w_beat_lim = r_state == LOAD_Q ? BW'(Q_BEATS - 1) :
                      r_state == LOAD_O ? BW'(O_BEATS - 1) : BW'(KV_BEATS - 1);
  assign w_hs        = weight_in_valid & weight_in_ready;
  assign w_last_beat = w_hs && (r_beat == w_beat_lim);
  assign w_last_pass = r_pass == PW'(NUM_PASSES - 1);
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_pass_nxt  = r_pass;
    w_done_nxt  = 1'b0;
    if (r_state == IDLE) begin
      if (start) begin
        w_state_nxt = LOAD_Q;
        w_beat_nxt  = '0;
        w_pass_nxt  = '0;
      end
    end else if (w_last_beat) begin
      w_beat_nxt  = '0;
      w_state_nxt = r_state == LOAD_Q ? LOAD_K : r_state == LOAD_K ? LOAD_V :
                    r_state == LOAD_V ? LOAD_O : w_last_pass ? IDLE : LOAD_Q;
      w_pass_nxt  = r_state != LOAD_O ? r_pass : w_last_pass ? '0 : r_pass + 1'b1;
      w_done_nxt  = (r_state == LOAD_O) && w_last_pass;
    end else if (w_hs) begin
      w_beat_nxt = r_beat + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_pass  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_pass  <= w_pass_nxt;
      r_done  <= w_done_nxt;
    end
  end
endmodule

// File: tb/tb_fixed_gqa_weight_scheduler.sv
// tb_fixed_gqa_weight_scheduler: scoreboard bench for the Q/K/V/O weight scheduler (1-pass and 2-pass builds)
module tb_fixed_gqa_weight_scheduler;
  localparam int DW = 32;
  logic clk = 0, rst = 0, start1 = 0, start2 = 0, weight_in_valid = 1, use2 = 0, rand_valid = 0;
  logic [DW-1:0] weight_in = '0;
  logic [3:0] tgt_rdy = 4'hf;
  logic busy1, busy2, done1, done2, rdy1, rdy2;
  logic [1:0] sel1, sel2;
  logic [3:0] vld1, vld2;
  logic [3:0][DW-1:0] wd1, wd2;
  int checks = 0, failures = 0;
  logic [1:0] exp_q[$];
  logic ob_hs, ob_done, ob_busy, ob_rdy;
  logic [1:0] ob_sel;
  logic [3:0] ob_vld;
  logic [DW-1:0] ob_dat, ob_win;

  always #5 clk = ~clk;

  fixed_gqa_weight_scheduler #(.WEIGHT_PRECISION_0(8), .WEIGHT_PARALLELISM(4), .Q_BEATS(4),
    .KV_BEATS(2), .O_BEATS(4), .NUM_PASSES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .sel(sel1),
    .weight_in(weight_in), .weight_in_valid(weight_in_valid), .weight_in_ready(rdy1),
    .q_projection_weight(wd1[0]), .k_projection_weight(wd1[1]),
    .v_projection_weight(wd1[2]), .o_projection_weight(wd1[3]),
    .q_projection_weight_valid(vld1[0]), .k_projection_weight_valid(vld1[1]),
    .v_projection_weight_valid(vld1[2]), .o_projection_weight_valid(vld1[3]),
    .q_projection_weight_ready(tgt_rdy[0]), .k_projection_weight_ready(tgt_rdy[1]),
    .v_projection_weight_ready(tgt_rdy[2]), .o_projection_weight_ready(tgt_rdy[3]));

  fixed_gqa_weight_scheduler #(.WEIGHT_PRECISION_0(8), .WEIGHT_PARALLELISM(4), .Q_BEATS(4),
    .KV_BEATS(2), .O_BEATS(4), .NUM_PASSES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .sel(sel2),
    .weight_in(weight_in), .weight_in_valid(weight_in_valid), .weight_in_ready(rdy2),
    .q_projection_weight(wd2[0]), .k_projection_weight(wd2[1]),
    .v_projection_weight(wd2[2]), .o_projection_weight(wd2[3]),
    .q_projection_weight_valid(vld2[0]), .k_projection_weight_valid(vld2[1]),
    .v_projection_weight_valid(vld2[2]), .o_projection_weight_valid(vld2[3]),
    .q_projection_weight_ready(tgt_rdy[0]), .k_projection_weight_ready(tgt_rdy[1]),
    .v_projection_weight_ready(tgt_rdy[2]), .o_projection_weight_ready(tgt_rdy[3]));

  task automatic push_run(input int passes);
    for (int p = 0; p < passes; p++) begin
      repeat (4) exp_q.push_back(2'd0);
      repeat (2) exp_q.push_back(2'd1);
      repeat (2) exp_q.push_back(2'd2);
      repeat (4) exp_q.push_back(2'd3);
    end
  endtask

  // samples the selected DUT mid-cycle, then advances one clock and drives fresh data
  task automatic step();
    @(negedge clk);
    ob_rdy  = use2 ? rdy2 : rdy1;
    ob_hs   = weight_in_valid && ob_rdy;
    ob_sel  = use2 ? sel2 : sel1;
    ob_vld  = use2 ? vld2 : vld1;
    ob_dat  = use2 ? wd2[ob_sel] : wd1[ob_sel];
    ob_win  = weight_in;
    ob_done = use2 ? done2 : done1;
    ob_busy = use2 ? busy2 : busy1;
    @(posedge clk);
    #1;
    weight_in = DW'($urandom);
    weight_in_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (busy1 !== 0 || done1 !== 0 || sel1 !== 0) begin failures++; $display("FAIL reset_status busy=%b done=%b sel=%0d expected 0 0 0", busy1, done1, sel1); end
    checks++; if (rdy1 !== 0 || vld1 !== 4'b0 || vld2 !== 4'b0) begin failures++; $display("FAIL reset_handshake rdy=%b vld1=%b vld2=%b expected 0 0000 0000", rdy1, vld1, vld2); end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    step();
    checks++; if (ob_rdy !== 0 || ob_vld !== 4'b0 || ob_busy !== 0) begin failures++; $display("FAIL idle_outputs rdy=%b vld=%b busy=%b expected 0 0000 0", ob_rdy, ob_vld, ob_busy); end
  endtask

  task automatic test_basic();
    logic [1:0] e;
    int n = 0;
    push_run(1);
    start1 = 1; step(); start1 = 0;
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      step();
      checks++; if (ob_done !== 0 || ob_busy !== 1) begin failures++; $display("FAIL basic_running done=%b busy=%b expected 0 1", ob_done, ob_busy); end
      if (ob_hs) begin
        e = exp_q.pop_front();
        checks++; if (ob_sel !== e || ob_vld !== (4'b1 << e) || ob_dat !== ob_win) begin failures++; $display("FAIL basic_hs%0d sel=%0d vld=%b dat=%h expected sel=%0d vld=%b dat=%h", n, ob_sel, ob_vld, ob_dat, e, 4'b1 << e, ob_win); end
        n++;
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL basic_timeout left=%0d expected 0", exp_q.size()); exp_q.delete(); end
    step();
    checks++; if (ob_done !== 1 || ob_busy !== 0) begin failures++; $display("FAIL basic_done done=%b busy=%b expected 1 0", ob_done, ob_busy); end
    step();
    checks++; if (ob_done !== 0) begin failures++; $display("FAIL basic_done_pulse done=%b expected 0", ob_done); end
  endtask

  task automatic test_backpressure();
    logic [1:0] e;
    int n = 0, nk = 0, stall = 0;
    push_run(1);
    start1 = 1; step(); start1 = 0;
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      step();
      if (stall > 0) begin
        checks++; if (ob_rdy !== 0 || ob_hs !== 0 || ob_sel !== 1 || ob_vld !== 4'b0010) begin failures++; $display("FAIL bp_stall rdy=%b sel=%0d vld=%b expected 0 1 0010", ob_rdy, ob_sel, ob_vld); end
        stall--;
        if (stall == 0) tgt_rdy[1] = 1;
      end
      if (ob_hs) begin
        e = exp_q.pop_front();
        checks++; if (ob_sel !== e || ob_dat !== ob_win) begin failures++; $display("FAIL bp_hs%0d sel=%0d dat=%h expected sel=%0d dat=%h", n, ob_sel, ob_dat, e, ob_win); end
        if (ob_sel == 1) nk++;
        n++;
        if (n == 5) begin tgt_rdy[1] = 0; stall = 5; end
      end
    end
    tgt_rdy = 4'hf;
    checks++; if (exp_q.size() != 0 || nk != 2) begin failures++; $display("FAIL bp_count k_beats=%0d left=%0d expected 2 0", nk, exp_q.size()); exp_q.delete(); end
    step();
    checks++; if (ob_done !== 1) begin failures++; $display("FAIL bp_done done=%b expected 1", ob_done); end
  endtask

  task automatic test_two_pass();
    logic [1:0] e;
    int n = 0;
    use2 = 1; rand_valid = 1;
    push_run(2);
    start2 = 1; step(); start2 = 0;
    for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
      step();
      checks++; if (ob_done !== 0) begin failures++; $display("FAIL two_pass_early_done at_hs=%0d done=%b expected 0", n, ob_done); end
      if (ob_hs) begin
        e = exp_q.pop_front();
        checks++; if (ob_sel !== e || ob_vld !== (4'b1 << e) || ob_dat !== ob_win) begin failures++; $display("FAIL two_pass_hs%0d sel=%0d vld=%b expected sel=%0d vld=%b", n, ob_sel, ob_vld, e, 4'b1 << e); end
        n++;
      end
    end
    checks++; if (exp_q.size() != 0 || n != 24) begin failures++; $display("FAIL two_pass_count hs=%0d expected 24", n); exp_q.delete(); end
    rand_valid = 0;
    step();
    checks++; if (ob_done !== 1 || ob_busy !== 0) begin failures++; $display("FAIL two_pass_done done=%b busy=%b expected 1 0", ob_done, ob_busy); end
    step();
    checks++; if (ob_done !== 0) begin failures++; $display("FAIL two_pass_done_pulse done=%b expected 0", ob_done); end
    use2 = 0;
  endtask

  task automatic test_start_ignored();
    logic [1:0] e;
    logic inj = 0;
    push_run(1);
    start1 = 1; step(); start1 = 0;
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      step();
      start1 = 0;
      if (ob_hs) begin
        e = exp_q.pop_front();
        checks++; if (ob_sel !== e) begin failures++; $display("FAIL ign_hs sel=%0d expected %0d", ob_sel, e); end
        if (e == 2 && !inj) begin start1 = 1; inj = 1; end
      end
    end
    start1 = 0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ign_timeout left=%0d expected 0", exp_q.size()); exp_q.delete(); end
    step();
    checks++; if (ob_done !== 1) begin failures++; $display("FAIL ign_done done=%b expected 1", ob_done); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ob_busy !== 0 || ob_done !== 0) begin failures++; $display("FAIL ign_restart busy=%b done=%b expected 0 0", ob_busy, ob_done); end
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] e;
    int n = 0;
    push_run(1);
    start1 = 1; step(); start1 = 0;
    for (int c = 0; c < 50 && n < 6; c++) begin
      step();
      if (ob_hs) begin exp_q.pop_front(); n++; end
    end
    #2 rst = 0;
    #1;
    checks++; if (busy1 !== 0 || done1 !== 0 || sel1 !== 0 || rdy1 !== 0 || vld1 !== 4'b0) begin failures++; $display("FAIL async_reset busy=%b done=%b sel=%0d rdy=%b vld=%b expected 0 0 0 0 0000", busy1, done1, sel1, rdy1, vld1); end
    exp_q.delete();
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    push_run(1);
    n = 0;
    start1 = 1; step(); start1 = 0;
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      step();
      if (ob_hs) begin
        e = exp_q.pop_front();
        checks++; if (ob_sel !== e || ob_dat !== ob_win) begin failures++; $display("FAIL rerun_hs%0d sel=%0d expected %0d", n, ob_sel, e); end
        n++;
      end
    end
    checks++; if (exp_q.size() != 0 || n != 12) begin failures++; $display("FAIL rerun_count hs=%0d expected 12", n); exp_q.delete(); end
    step();
    checks++; if (ob_done !== 1) begin failures++; $display("FAIL rerun_done done=%b expected 1", ob_done); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] e;
    push_run(1);
    start1 = 1; step(); start1 = 0;
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      step();
      if (ob_hs) begin
        e = exp_q.pop_front();
        checks++; if (ob_sel !== e) begin failures++; $display("FAIL b2b_first_hs sel=%0d expected %0d", ob_sel, e); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_first_timeout left=%0d expected 0", exp_q.size()); exp_q.delete(); end
    start1 = 1; step(); start1 = 0;
    checks++; if (ob_done !== 1 || ob_busy !== 0) begin failures++; $display("FAIL b2b_done_cycle done=%b busy=%b expected 1 0", ob_done, ob_busy); end
    push_run(1);
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      step();
      if (c == 0) begin
        checks++; if (ob_busy !== 1 || ob_sel !== 0 || ob_hs !== 1) begin failures++; $display("FAIL b2b_restart busy=%b sel=%0d hs=%b expected 1 0 1", ob_busy, ob_sel, ob_hs); end
      end
      if (ob_hs) begin
        e = exp_q.pop_front();
        checks++; if (ob_sel !== e || ob_dat !== ob_win) begin failures++; $display("FAIL b2b_second_hs sel=%0d expected %0d", ob_sel, e); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_second_timeout left=%0d expected 0", exp_q.size()); exp_q.delete(); end
    step();
    checks++; if (ob_done !== 1) begin failures++; $display("FAIL b2b_second_done done=%b expected 1", ob_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_two_pass();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
